// File: rtl/rom_burst_arbiter_if.sv
// Bundle of all rom_burst_arbiter signals except clk/rst: requester ports,
// ROM port, tagged return stream and a state debug tap.
//
// Handshake semantics:
//   - Request side: req is held high with a stable addr/len until the
//     matching gnt pulse. gnt is high for exactly one cycle. addr/len are
//     captured on the edge that raises gnt.
//   - Return side: d_valid qualifies d_out, d_id and d_last in the same
//     cycle. There is no back-pressure, so every beat is consumed the cycle
//     it is presented.
interface rom_burst_arbiter_if;
  logic       req0;
  logic       req1;
  logic [2:0] addr0;
  logic [2:0] addr1;
  logic [2:0] len0;
  logic [2:0] len1;
  logic       gnt0;
  logic       gnt1;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] d_out;
  logic       d_valid;
  logic       d_id;
  logic       d_last;
  logic       busy;
  logic [1:0] dbg_state;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_data,
    output gnt0, gnt1, rom_addr, d_out, d_valid, d_id, d_last, busy, dbg_state
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_data,
    input  gnt0, gnt1, rom_addr, d_out, d_valid, d_id, d_last, busy, dbg_state
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one 8x8 registered-read ROM between two burst
// requesters; returns each burst as a tagged, back-to-back valid stream.
module rom_burst_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  rom_burst_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       grant;
  logic       winner;
  logic       last_winner;

  logic [2:0] rom_addr_q;
  logic [2:0] cnt;
  logic [2:0] cur_len;
  logic       cur_id;
  logic       gnt0_q;
  logic       gnt1_q;

  // Stage aligned with the ROM's registered output.
  logic       p_valid;
  logic       p_last;
  logic       p_id;

  logic [7:0] d_out_q;
  logic       d_valid_q;
  logic       d_id_q;
  logic       d_last_q;

  logic       issuing;
  logic       issue_done;

  assign issuing    = (state == ISSUE);
  assign issue_done = (cnt == cur_len);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant     = 1'b1;
          // On a tie, the requester that did not win last time goes first.
          if (bus.req0 && bus.req1) winner = ~last_winner;
          else                      winner = bus.req1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last address's word is captured into d_out on this edge.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q  <= 3'd0;
      cnt         <= 3'd0;
      cur_len     <= 3'd0;
      cur_id      <= 1'b0;
      last_winner <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
    end else begin
      gnt0_q <= grant & ~winner;
      gnt1_q <= grant & winner;
      if (grant) begin
        rom_addr_q  <= winner ? bus.addr1 : bus.addr0;
        cur_len     <= winner ? bus.len1 : bus.len0;
        cur_id      <= winner;
        cnt         <= 3'd0;
        last_winner <= winner;
      end else if (issuing && !issue_done) begin
        rom_addr_q <= rom_addr_q + 3'd1;
        cnt        <= cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      p_id      <= 1'b0;
      d_out_q   <= 8'd0;
      d_valid_q <= 1'b0;
      d_id_q    <= 1'b0;
      d_last_q  <= 1'b0;
    end else begin
      p_valid   <= issuing;
      p_last    <= issuing && issue_done;
      p_id      <= cur_id;
      d_valid_q <= p_valid;
      d_last_q  <= p_valid && p_last;
      if (p_valid) begin
        d_out_q <= bus.rom_data;
        d_id_q  <= p_id;
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_id      = d_id_q;
  assign bus.d_last    = d_last_q;
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter: directed scenarios plus random
// bursts, with a queue-based scoreboard fed by a transaction-level model.
module tb_rom_burst_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;

  rom_burst_arbiter_if bus ();

  rom_burst_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ROM model: registered read, ROM[i] = 8'hA0 | i.
  always @(posedge clk) bus.rom_data <= 8'hA0 | {5'd0, bus.rom_addr};

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];   // {id, last, data}
  logic       gnt_q[$];   // expected grant order
  logic       model_last = 1'b1;

  int gnt_cycle       = 0;
  int beat_idx        = 0;
  int busy_cnt        = 0;
  int last_beat_cycle = 0;
  int beats_seen      = 0;
  bit waiting         = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted burst returns ROM words start..start+len mod 8.
  task automatic push_burst(input logic id, input logic [2:0] a, input logic [2:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      logic [2:0] ad;
      logic       lst;
      ad  = a + 3'(i);
      lst = (i == int'(l));
      exp_q.push_back({id, lst, 8'hA0 | {5'd0, ad}});
    end
  endtask

  task automatic predict_one(input logic id, input logic [2:0] a, input logic [2:0] l);
    gnt_q.push_back(id);
    push_burst(id, a, l);
    model_last = id;
  endtask

  task automatic predict_both(input logic [2:0] a0, input logic [2:0] l0,
                              input logic [2:0] a1, input logic [2:0] l1);
    logic w;
    w = ~model_last;
    if (w) begin
      predict_one(1'b1, a1, l1);
      predict_one(1'b0, a0, l0);
    end else begin
      predict_one(1'b0, a0, l0);
      predict_one(1'b1, a1, l1);
    end
  endtask

  // Requester driver: raise req, hold until gnt, then drop.
  task automatic do_req(input logic id, input logic [2:0] a, input logic [2:0] l);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (id) begin bus.req1 = 1'b1; bus.addr1 = a; bus.len1 = l; end
    else    begin bus.req0 = 1'b1; bus.addr0 = a; bus.len0 = l; end
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (id ? bus.gnt1 : bus.gnt0) begin
        got = 1'b1;
        break;
      end
    end
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
    check(id ? "req1_granted" : "req0_granted", got, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 80; k++) begin
      if (exp_q.size() == 0 && gnt_q.size() == 0) break;
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    check("drain_beats_left", exp_q.size(), 0);
    check("drain_gnts_left", gnt_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_d_valid", bus.d_valid, 0);
    check("rst_d_id", bus.d_id, 0);
    check("rst_d_last", bus.d_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_d_out", bus.d_out, 0);
  endtask

  // Monitor: pops expected grants/beats whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_exclusive", bus.gnt0 & bus.gnt1, 0);
        if (gnt_q.size() == 0) check("gnt_unexpected", 1, 0);
        else check("gnt_id", bus.gnt1, gnt_q.pop_front());
        check("busy_at_gnt", bus.busy, 1);
        if (waiting) check("gnt_after_wait_cycle", cycle, last_beat_cycle + 1);
        waiting   = 1'b0;
        gnt_cycle = cycle;
        beat_idx  = 0;
        busy_cnt  = 0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && (bus.req0 || bus.req1)) waiting = 1'b1;
      if (bus.d_valid) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          check("beat_id_last_data", {bus.d_id, bus.d_last, bus.d_out}, exp_q.pop_front());
          check("beat_cycle", cycle, gnt_cycle + 2 + beat_idx);
        end
        if (bus.d_last) begin
          check("busy_cycles", busy_cnt, beat_idx + 2);
          check("busy_after_last", bus.busy, 0);
          last_beat_cycle = cycle;
        end
        beat_idx++;
        beats_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 3'd0; bus.addr1 = 3'd0;
    bus.len0 = 3'd0;  bus.len1 = 3'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted mid-clock: outputs clear without waiting for an edge.
    #3 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk) rst = 1'b0;
    model_last = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_state", bus.dbg_state, 0);

    // Simultaneous requests right after reset, twice to see alternation.
    predict_both(3'd5, 3'd1, 3'd7, 3'd1);
    fork
      do_req(1'b0, 3'd5, 3'd1);
      do_req(1'b1, 3'd7, 3'd1);
    join
    wait_drain();
    predict_both(3'd2, 3'd2, 3'd4, 3'd0);
    fork
      do_req(1'b0, 3'd2, 3'd2);
      do_req(1'b1, 3'd4, 3'd0);
    join
    wait_drain();

    // Single word and wrapping burst.
    predict_one(1'b0, 3'd3, 3'd0);
    do_req(1'b0, 3'd3, 3'd0);
    wait_drain();
    predict_one(1'b1, 3'd6, 3'd3);
    do_req(1'b1, 3'd6, 3'd3);
    wait_drain();

    // Request raised during a full sweep waits for the sweep to finish.
    predict_one(1'b0, 3'd0, 3'd7);
    predict_one(1'b1, 3'd2, 3'd1);
    fork
      do_req(1'b0, 3'd0, 3'd7);
      begin
        repeat (5) @(posedge clk);
        do_req(1'b1, 3'd2, 3'd1);
      end
    join
    wait_drain();

    // Random bursts.
    for (int r = 0; r < 30; r++) begin
      int mode;
      logic [2:0] a0, l0, a1, l1;
      mode = $urandom_range(0, 2);
      a0 = 3'($urandom_range(0, 7)); l0 = 3'($urandom_range(0, 7));
      a1 = 3'($urandom_range(0, 7)); l1 = 3'($urandom_range(0, 7));
      if (mode == 0) begin
        predict_one(1'b0, a0, l0);
        do_req(1'b0, a0, l0);
      end else if (mode == 1) begin
        predict_one(1'b1, a1, l1);
        do_req(1'b1, a1, l1);
      end else begin
        predict_both(a0, l0, a1, l1);
        fork
          do_req(1'b0, a0, l0);
          do_req(1'b1, a1, l1);
        join
      end
      wait_drain();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset in the middle of a full sweep abandons the burst.
    predict_one(1'b0, 3'd1, 3'd7);
    base = beats_seen;
    do_req(1'b0, 3'd1, 3'd7);
    for (int k = 0; k < 20; k++) begin
      if (beats_seen >= base + 3) break;
      @(negedge clk); #1;
    end
    check("beats_before_reset", (beats_seen >= base + 3), 1);
    #2 rst = 1'b1;
    exp_q.delete();
    gnt_q.delete();
    waiting    = 1'b0;
    model_last = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    predict_one(1'b0, 3'd4, 3'd2);
    do_req(1'b0, 3'd4, 3'd2);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
